// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if
//   Operand and product handshakes of the sequential Booth multiplier.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : multiplier side (drives in_ready, out_valid, prod)
//   Signals:
//     in_valid/in_ready   operand handshake
//     a, b, is_signed     32-bit operands and signedness, sampled on accept
//     out_valid/out_ready product handshake
//     prod                64-bit registered product
interface booth_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] prod;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq
//   Iterative radix-4 Booth multiplier: one 32x32 operand pair per
//   transaction, 17 Booth digits retired one per clock into a 68-bit
//   accumulator, 64-bit product presented through a valid/ready handshake.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     abort  synchronous cancel, overrides every other input
//     busy   high while calculating or holding a result (CALC/DONE)
//     bus    operand/product handshakes (booth_mul_seq_if.slave)
module booth_mul_seq (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           abort,
    output logic           busy,
    booth_mul_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [67:0] acc_q;
    logic [67:0] mcand_q;   // sign-extended multiplicand, pre-shifted by 2i
    logic [33:0] mplr_q;    // extended multiplier, shifted right by 2 per digit
    logic        bprev_q;   // B[2i-1] of the current digit
    logic [63:0] prod_q;
    logic        out_valid_q;

    logic [2:0]  trip;
    logic [67:0] pp_d;
    logic [67:0] acc_d;
    logic        a_ext;
    logic        b_ext;

    assign a_ext = bus.is_signed & bus.a[31];
    assign b_ext = bus.is_signed & bus.b[31];

    // Booth triplet {B[2i+1], B[2i], B[2i-1]} of the digit retired this cycle
    assign trip = {mplr_q[1:0], bprev_q};

    always_comb begin
        pp_d = '0;
        case (trip)
            3'b001, 3'b010: pp_d = mcand_q;
            3'b011:         pp_d = mcand_q << 1;
            3'b100:         pp_d = -(mcand_q << 1);
            3'b101, 3'b110: pp_d = -mcand_q;
            default:        pp_d = '0;
        endcase
        acc_d = acc_q + pp_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            bprev_q     <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            // prod is deliberately kept: the last completed result survives a cancel
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q <= {{36{a_ext}}, bus.a};
                        mplr_q  <= {b_ext, b_ext, bus.b};
                        bprev_q <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 2;
                    mplr_q  <= {2'b00, mplr_q[33:2]};
                    bprev_q <= mplr_q[1];
                    cnt_q   <= cnt_q + 5'd1;
                    if (cnt_q == 5'd16) begin
                        prod_q      <= acc_d[63:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~abort;
    assign bus.out_valid = out_valid_q;
    assign bus.prod      = prod_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic busy;

    booth_mul_seq_if ifc ();

    booth_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (abort),
        .busy  (busy),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc_m = 0;
    int n_out_m = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake monitor; inputs change #1 after posedge so negedge values are
    // the ones seen by the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.in_valid && ifc.in_ready) n_acc_m++;
            if (ifc.out_valid && ifc.out_ready) n_out_m++;
            if (ifc.in_ready && ifc.out_valid) begin
                n_err++;
                $display("FAIL ready_valid_overlap: in_ready=%b out_valid=%b required not both 1",
                         ifc.in_ready, ifc.out_valid);
            end
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        int k;
        ifc.a = ta;
        ifc.b = tb_v;
        ifc.is_signed = ts;
        ifc.in_valid = 1'b1;
        k = 0;
        while (!ifc.in_ready && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ifc.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 60 cycles", ifc.in_ready);
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!ifc.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ifc.out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: out_valid=%b required 1 within 60 cycles", ifc.out_valid);
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          input int rd, output logic [63:0] p, output int lat);
        ifc.out_ready = (rd == 0);
        start_op(ta, tb_v, ts);
        wait_done(lat);
        p = ifc.prod;
        if (rd > 0) begin
            repeat (rd) begin @(posedge clk); #1; end
            ifc.out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] p;
        logic [63:0] p0;
        logic [63:0] sa;
        logic [63:0] sb;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          lat;
        bit          seen;

        vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vecs[1]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[2]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[4]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080};
        vecs[5]  = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F};
        vecs[6]  = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1};
        vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
        vecs[8]  = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE};
        vecs[9]  = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
        vecs[10] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000000000000000};

        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.is_signed = 1'b0;
        ifc.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, ifc.out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_prod", ifc.prod, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {63'b0, ifc.in_ready}, 64'd1);

        // Directed vectors, zero backpressure
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, p, lat);
            chk($sformatf("vec%0d_prod", i), p, vecs[i].p);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
        end

        // Backpressure: hold out_ready low for 10 cycles
        ifc.out_ready = 1'b0;
        start_op(32'h12345678, 32'h9ABCDEF0, 1'b0);
        wait_done(lat);
        p0 = ifc.prod;
        chk("bp_prod", p0, 64'h0B00EA4E242D2080);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {63'b0, ifc.out_valid}, 64'd1);
            chk("bp_prod_stable", ifc.prod, p0);
            chk("bp_in_ready", {63'b0, ifc.in_ready}, 64'd0);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", {63'b0, ifc.out_valid}, 64'd0);
        chk("bp_release_in_ready", {63'b0, ifc.in_ready}, 64'd1);
        chk("bp_release_busy", {63'b0, busy}, 64'd0);
        chk("bp_release_prod", ifc.prod, 64'h0B00EA4E242D2080);

        // Abort during the 5th CALC cycle
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_busy_before", {63'b0, busy}, 64'd1);
        abort = 1'b1;
        #1;
        chk("abort_in_ready_low", {63'b0, ifc.in_ready}, 64'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_out_valid", {63'b0, ifc.out_valid}, 64'd0);
        chk("abort_prod_kept", ifc.prod, 64'h0B00EA4E242D2080);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ifc.out_valid) seen = 1'b1;
        end
        chk("abort_no_result", {63'b0, seen}, 64'd0);

        // Abort in IDLE with in_valid high blocks the accept
        abort = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.a = 32'd7;
        ifc.b = 32'd7;
        #1;
        chk("abort_idle_in_ready", {63'b0, ifc.in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("abort_idle_busy", {63'b0, busy}, 64'd0);
        abort = 1'b0;
        ifc.in_valid = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, 0, p, lat);
        chk("post_abort_prod", p, 64'h000000000000000F);

        // Asynchronous reset mid-CALC
        start_op(32'd5, 32'd7, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'b0, ifc.out_valid}, 64'd0);
        chk("async_rst_busy", {63'b0, busy}, 64'd0);
        chk("async_rst_prod", ifc.prod, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("async_rst_in_ready", {63'b0, ifc.in_ready}, 64'd1);
        chk("async_rst_idle_out_valid", {63'b0, ifc.out_valid}, 64'd0);
        run_op(32'd5, 32'd7, 1'b0, 0, p, lat);
        chk("post_rst_prod", p, 64'd35);

        // Random operands with input gaps and output backpressure
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            sa = rs ? {{32{ra[31]}}, ra} : {32'b0, ra};
            sb = rs ? {{32{rb[31]}}, rb} : {32'b0, rb};
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), p, lat);
            chk($sformatf("rand%0d_prod a=%h b=%h s=%b", i, ra, rb, rs), p, sa * sb);
        end

        // Two accepted operations (abort, reset) never produce an output
        @(posedge clk); #1;
        chk("accept_output_count", 64'(n_out_m), 64'(n_acc_m - 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Iterative radix-4 Booth multiplier sequencer for 32x32 products. It accepts one operand pair through a valid/ready handshake and steps through the 17 Booth digits of the multiplier, one per clock. Each digit's partial product is added into a 68-bit accumulator. It is the low-area, multi-cycle alternative to the single-cycle 17-partial-product adder tree, and it presents a full 64-bit product through a second valid/ready handshake.

## Interface
- No parameters; widths are fixed (32-bit operands, 17 digits, 68-bit accumulator, 64-bit product).
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept; equals (state==IDLE) & ~abort
- a  in  32  multiplicand
- b  in  32  multiplier
- is_signed  in  1  1: a, b two's complement; 0: unsigned; sampled with a, b
- abort  in  1  synchronous cancel; priority over all other inputs
- out_valid  out  1  prod valid; held until out_ready
- out_ready  in  1  consumer accepts prod
- prod  out  64  product, registered
- busy  out  1  high in CALC or DONE

## Operation
- States: IDLE, CALC, DONE. Reset (rst_n=0, asynchronous) forces IDLE, digit counter 0, accumulator 0, prod 0, out_valid 0, busy 0. in_ready is 1 after reset release while abort=0.
- IDLE: accept when in_valid & in_ready. Latch A = {ext,ext,a} and B = {ext,ext,b}, 34 bits each, where ext = is_signed ? msb : 0. Clear the accumulator and the counter i, then go to CALC.
- CALC: each cycle, digit d_i = -2*B[2i+1] + B[2i] + B[2i-1], with B[-1]=0 and d_i in {-2,-1,0,1,2}.
  - acc <= acc + sign_extend_68(d_i*A) << 2i, modulo 2^68.
  - i increments each cycle. After i=16 is added, load prod <= acc_next[63:0], set out_valid and go to DONE.
- DONE: out_valid=1 and prod is stable. When out_valid & out_ready, clear out_valid and go to IDLE. prod holds its value until the next completion; it is not cleared.
- abort=1 in any state: next edge goes to IDLE, clears out_valid, acc and i, and leaves prod unchanged. abort=1 in IDLE with in_valid=1 means no accept, because in_ready is low.
- No overlap: a new operand pair is accepted only in IDLE.
- Unsigned products up to (2^32-1)^2 fit in 64 bits. Signed products are exact in 64-bit two's complement.

## Timing
- Accept at edge E0, then CALC for edges E1..E17 (17 digit additions). out_valid rises after E17.
- Output handshake at E18 at the earliest, giving IDLE after E18. The next accept is at E19, so throughput is 1 product per 19 cycles with zero backpressure.
- out_ready held low keeps DONE indefinitely, with prod and out_valid stable.
- in_ready and out_valid never both high.
- Reset asserted mid-CALC or mid-DONE clears immediately (asynchronous). After release the block sits in IDLE with out_valid=0.

## Test plan
- Reset: assert rst_n=0 mid-CALC -> out_valid=0, busy=0, prod=0 asynchronously. After release, in_ready=1.
- Signed corner cases, out_ready=1:
  - a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=1 -> prod=0x0000000000000001, out_valid exactly 17 edges after accept.
  - a=0x80000000, b=0x80000000, is_signed=1 -> 0x4000000000000000.
  - a=0x80000000, b=0x00000001, is_signed=1 -> 0xFFFFFFFF80000000.
- Unsigned corner case: a=b=0xFFFFFFFF, is_signed=0 -> 0xFFFFFFFE00000001. a=0x12345678, b=0x9ABCDEF0 -> 0x0B00EA4E242D2080.
- Backpressure: hold out_ready=0 for 10 cycles after completion -> out_valid and prod stable, in_ready=0. Raise out_ready -> one handshake, then IDLE next cycle.
- Abort: pulse abort at the 5th CALC cycle -> IDLE next edge, no out_valid, prod keeps previous result. The next op (3 x 5, unsigned) returns 0x000000000000000F.
- Random: 10k random a, b, is_signed with random in_valid and out_ready gaps -> every prod equals the reference 64-bit product, and the count of outputs equals the count of accepts.
